// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_pkg
//  Description : Shared types and constants for the multi-word adder
//                sequencer: word width, FSM state enum, result record.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_seq_pkg;

    // Word width of the single prefix adder shared by the datapath
    localparam int ADDER_WIDTH = 16;

    // Storage width of the word-count field in the result record; the
    // sequencer keeps MAX_WORDS small enough that its counter is narrower
    localparam int WORDS_FIELD_W = 8;
    localparam int MAX_WORDS_LIMIT = 127;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDER_WIDTH-1:0]   sum;
        logic                     last;
        logic                     cout;
        logic                     err;
        logic [WORDS_FIELD_W-1:0] words;
    } result_t;

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder
//  Description : WIDTH-bit parallel-prefix (Kogge-Stone) adder with carry-in
//                and carry-out. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] w_gk;
    logic [WIDTH-1:0] w_pk;
    logic [WIDTH-1:0] w_gn;
    logic [WIDTH-1:0] w_pn;
    logic [WIDTH:0]   w_carry;

    // Prefix tree: after LEVELS stages w_gk[i]/w_pk[i] span bits [i:0],
    // so each carry only needs the group terms combined with cin
    always_comb begin
        w_gk    = a & b;
        w_pk    = a ^ b;
        w_gn    = w_gk;
        w_pn    = w_pk;
        w_carry = '0;
        for (int lv = 0; lv < LEVELS; lv++) begin
            w_gn = w_gk;
            w_pn = w_pk;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << lv)) begin
                    w_gn[i] = w_gk[i] | (w_pk[i] & w_gk[i - (1 << lv)]);
                    w_pn[i] = w_pk[i] & w_pk[i - (1 << lv)];
                end
            end
            w_gk = w_gn;
            w_pk = w_pn;
        end
        w_carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i+1] = w_gk[i] | (w_pk[i] & cin);
        end
    end

    assign sum  = (a ^ b) ^ w_carry[WIDTH-1:0];
    assign cout = w_carry[WIDTH];

endmodule : adder
`default_nettype wire

// File: rtl/adder_word_seq.sv
`default_nettype none
// ============================================================================
//  Module      : adder_word_seq
//  Description : Streaming multi-word adder sequencer. Takes operand pairs one
//                word per beat (LS word first), chains the carry through a
//                single 16-bit prefix adder and registers each sum word.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_word_seq
    import adder_seq_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int MAX_WORDS = 8,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_err,
    output logic [CNT_W-1:0] out_words
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_WORDS);

    // Parameter sanity: the datapath is tied to the shared 16-bit adder
    generate
        if (WIDTH != ADDER_WIDTH) begin : g_width_check
            $error("adder_word_seq: WIDTH must equal the adder width (16)");
        end
        if (MAX_WORDS < 1 || MAX_WORDS > MAX_WORDS_LIMIT) begin : g_max_words_check
            $error("adder_word_seq: MAX_WORDS out of supported range");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    result_t          r_out;

    logic             w_accept;
    logic             w_start;
    logic             w_err_proto;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [CNT_W-1:0] w_words_next;
    logic             w_overflow;
    logic             w_last;
    logic             w_err;
    logic             w_unused_words;

    assign in_ready = !r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: an accepted beat that closes the operand returns to IDLE
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_last ? IDLE : BUSY;
        end
    end

    // FSM outputs: does this beat start an operand, and is it out of protocol
    always_comb begin
        w_start     = 1'b1;
        w_err_proto = 1'b0;
        case (r_state)
            IDLE: begin
                w_start     = 1'b1;
                w_err_proto = !in_first;
            end
            BUSY: begin
                w_start     = in_first;
                w_err_proto = in_first;
            end
            default: begin
                w_start     = 1'b1;
                w_err_proto = 1'b0;
            end
        endcase
    end

    // Per-beat datapath controls: carry select, word count, length overflow
    always_comb begin
        w_cin        = w_start ? in_cin : r_carry;
        w_words_next = w_start ? c_ONE : (r_count + 1'b1);
        w_overflow   = (w_words_next == c_MAX) & !in_last;
        w_last       = in_last | w_overflow;
        w_err        = w_err_proto | w_overflow;
    end

    // Carry chain and word counter advance only on an accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_carry <= w_cout;
            r_count <= w_words_next;
        end
    end

    // One-entry output register; loads on accept, drains on out handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out.sum   <= w_sum;
            r_out.last  <= w_last;
            r_out.cout  <= w_cout;
            r_out.err   <= w_err;
            r_out.words <= {{(WORDS_FIELD_W - CNT_W){1'b0}}, w_words_next};
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_sum        = r_out.sum;
    assign out_last       = r_out.last;
    assign out_cout       = r_out.cout;
    assign out_err        = r_out.err;
    assign out_words      = r_out.words[CNT_W-1:0];
    assign w_unused_words = ^r_out.words[WORDS_FIELD_W-1:CNT_W];

endmodule : adder_word_seq
`default_nettype wire

// File: tb/tb_adder_word_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_word_seq
//  Description : Self-checking bench for adder_word_seq: directed scenarios
//                plus randomized traffic against a word-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_word_seq;

    localparam int W     = 16;
    localparam int MAXW  = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_first;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_last;
    logic          out_cout;
    logic          out_err;
    logic [CW-1:0] out_words;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          last;
        logic          cout;
        logic          err;
        logic [CW-1:0] words;
    } exp_t;

    // Reference model state: inside an operand or not, words so far, carry
    bit m_busy;
    int m_count;
    bit m_carry;

    always #5 clk = ~clk;

    adder_word_seq #(
        .WIDTH     (W),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_err   (out_err),
        .out_words (out_words)
    );

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_count = 0;
        m_carry = 1'b0;
    endfunction

    // Word-level model of one accepted beat: plain 17-bit addition
    function automatic exp_t model_step(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic first, input logic last);
        exp_t        e;
        bit          start;
        bit          perr;
        bit          ovf;
        int          words;
        logic [W:0]  total;
        start = !m_busy || first;
        perr  = (m_busy && first) || (!m_busy && !first);
        words = start ? 1 : m_count + 1;
        total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (start ? cin : m_carry)};
        ovf   = (words == MAXW) && !last;
        e.sum   = total[W-1:0];
        e.cout  = total[W];
        e.last  = last || ovf;
        e.err   = perr || ovf;
        e.words = CW'(words);
        m_carry = total[W];
        m_count = words;
        m_busy  = !(last || ovf);
        return e;
    endfunction

    // Presents one beat and advances past the next rising edge
    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic first, input logic last);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h",
                     {out_valid, out_sum, out_last, out_cout, out_err, out_words}, 24'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_single_word();
        exp_t e;
        drive_beat(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        e = model_step(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL single_word got %h want %h",
                     {out_valid, out_sum, out_last, out_cout, out_err, out_words},
                     {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd1});
        end
        idle_cycle();
    endtask

    task automatic test_three_word();
        exp_t        e;
        logic [23:0] want;
        for (int i = 0; i < 3; i++) begin
            drive_beat(16'hFFFF, (i == 0) ? 16'h0001 : 16'h0000, 1'b0, i == 0, i == 2);
            e    = model_step(16'hFFFF, (i == 0) ? 16'h0001 : 16'h0000, 1'b0, i == 0, i == 2);
            want = {1'b1, 16'h0000, (i == 2), 1'b1, 1'b0, CW'(i + 1)};
            checks++;
            if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== want) begin
                errors++;
                $display("FAIL three_word[%0d] got %h want %h", i,
                         {out_valid, out_sum, out_last, out_cout, out_err, out_words}, want);
            end
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [23:0] want1;
        logic [23:0] want2;
        want1     = {1'b1, 16'h2345, 1'b0, 1'b0, 1'b0, 4'd1};
        want2     = {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd2};
        out_ready = 1'b0;
        drive_beat(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b0);
        e = model_step(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b0);
        // Second beat waits while the output is stalled
        in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b1; in_first = 1'b0; in_last = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 ||
                {out_valid, out_sum, out_last, out_cout, out_err, out_words} !== want1) begin
                errors++;
                $display("FAIL stall[%0d] got ready=%b out=%h want ready=0 out=%h", c, in_ready,
                         {out_valid, out_sum, out_last, out_cout, out_err, out_words}, want1);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model_step(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== want2) begin
            errors++;
            $display("FAIL stall_second_beat got %h want %h",
                     {out_valid, out_sum, out_last, out_cout, out_err, out_words}, want2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_duplicate got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        for (int i = 0; i < MAXW; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            drive_beat(a, b, c, i == 0, 1'b0);
            e = model_step(a, b, c, i == 0, 1'b0);
            checks++;
            if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== {1'b1, e}) begin
                errors++;
                $display("FAIL overflow_beat[%0d] got %h want %h", i,
                         {out_valid, out_sum, out_last, out_cout, out_err, out_words}, {1'b1, e});
            end
        end
        checks++;
        if ({out_last, out_err, out_words} !== {1'b1, 1'b1, 4'd8}) begin
            errors++;
            $display("FAIL overflow_flags got last=%b err=%b words=%0d want 1 1 8",
                     out_last, out_err, out_words);
        end
        drive_beat(16'h0102, 16'h0304, 1'b0, 1'b1, 1'b1);
        e = model_step(16'h0102, 16'h0304, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== {1'b1, 16'h0406, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL overflow_recover got %h want %h",
                     {out_valid, out_sum, out_last, out_cout, out_err, out_words},
                     {1'b1, 16'h0406, 1'b1, 1'b0, 1'b0, 4'd1});
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive_beat(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        e = model_step(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        drive_beat(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        e = model_step(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_sum, out_cout, out_words} !== {1'b1, 16'h0000, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL midreset_word2 got %h want %h",
                     {out_valid, out_sum, out_cout, out_words}, {1'b1, 16'h0000, 1'b1, 4'd2});
        end
        // Reset lands together with a valid beat; the beat must be dropped
        rst = 1'b1;
        in_a = 16'h1111; in_b = 16'h1111; in_cin = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        model_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got %b want 0", out_valid);
        end
        drive_beat(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        e = model_step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL midreset_fresh_cin got %h want %h",
                     {out_valid, out_sum, out_last, out_cout, out_err, out_words},
                     {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1});
        end
        idle_cycle();
    endtask

    task automatic test_restart();
        exp_t e;
        drive_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        e = model_step(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        drive_beat(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b1);
        e = model_step(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== {1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL restart_busy got %h want %h",
                     {out_valid, out_sum, out_last, out_cout, out_err, out_words},
                     {1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 4'd1});
        end
        // Non-first beat while idle is taken as a first beat using in_cin
        drive_beat(16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b1);
        e = model_step(16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_err, out_words} !== {1'b1, 16'h0101, 1'b1, 1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL idle_not_first got %h want %h",
                     {out_valid, out_sum, out_last, out_cout, out_err, out_words},
                     {1'b1, 16'h0101, 1'b1, 1'b0, 1'b1, 4'd1});
        end
        idle_cycle();
    endtask

    // Random traffic with random downstream stalls, tracked by the model
    task automatic test_random();
        exp_t e;
        bit   e_valid;
        bit   acc;
        bit   want_ready;
        e       = '0;
        e_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = W'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? ~in_a : W'($urandom);
            in_cin    = 1'($urandom);
            in_first  = ($urandom_range(0, 4) == 0);
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            want_ready = !e_valid || out_ready;
            acc        = in_valid && want_ready;
            checks++;
            if (in_ready !== want_ready) begin
                errors++;
                $display("FAIL random_ready[%0d] got %b want %b", n, in_ready, want_ready);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                e       = model_step(in_a, in_b, in_cin, in_first, in_last);
                e_valid = 1'b1;
            end else if (out_ready) begin
                e_valid = 1'b0;
            end
            checks++;
            if (out_valid !== e_valid ||
                (e_valid && {out_sum, out_last, out_cout, out_err, out_words} !== e)) begin
                errors++;
                $display("FAIL random_out[%0d] got v=%b %h want v=%b %h", n, out_valid,
                         {out_sum, out_last, out_cout, out_err, out_words}, e_valid, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_three_word();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder_word_seq
`default_nettype wire
